// File: rtl/perceptron_train_ctrl.sv
// perceptron_train_ctrl
//   Training sequencer for the perceptron datapath. Walks the sample ROM in
//   address order, one epoch per pass, firing one classify/update step per
//   sample and counting misclassifications. Training stops on the first
//   error-free epoch (converged) or after MAX_EPOCHS epochs.
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, abort    begin training (IDLE/DONE only) / synchronous return to IDLE
//   rom_addr        address to the combinational sample ROM
//   ld_sample       1-cycle pulse: datapath latches ROM data
//   dp_start        1-cycle pulse: datapath begins classify/update
//   dp_done, dp_err datapath step complete / sample was misclassified
//   busy, done      run in progress / run finished (held)
//   converged       valid with done: last epoch had no errors
//   epoch_cnt       epochs completed in this run
//   last_epoch_err  error count of the last completed epoch (saturating)
module perceptron_train_ctrl #(
  parameter int unsigned N_SAMPLES  = 200,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned MAX_EPOCHS = 100,
  parameter int unsigned EPOCH_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               ld_sample,
  output logic               dp_start,
  input  logic               dp_done,
  input  logic               dp_err,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic [7:0]         last_epoch_err
);

  localparam int unsigned IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [ADDR_W-1:0]  ADDR_FIRST  = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_LIMIT = EPOCH_W'(MAX_EPOCHS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_EPOCH_END,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [7:0]       err;
  logic             epoch_stop;

  // Training ends after an error-free epoch or when the epoch limit is reached.
  assign epoch_stop = (err == '0) || ((epoch_cnt + EPOCH_W'(1)) == EPOCH_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_next = S_ADDR;
        S_ADDR:         state_next = S_LOAD;
        S_LOAD:         state_next = S_FIRE;
        S_FIRE:         state_next = S_WAIT;
        S_WAIT:         if (dp_done) state_next = (idx == IDX_LAST) ? S_EPOCH_END : S_ADDR;
        S_EPOCH_END:    state_next = epoch_stop ? S_DONE : S_ADDR;
        default:        state_next = S_IDLE;
      endcase
    end
  end

  // Pulses are registered from the next state so they coincide with LOAD/FIRE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr       <= ADDR_FIRST;
      ld_sample      <= 1'b0;
      dp_start       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      converged      <= 1'b0;
      epoch_cnt      <= '0;
      last_epoch_err <= '0;
      idx            <= '0;
      err            <= '0;
    end else if (abort) begin
      ld_sample <= 1'b0;
      dp_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else begin
      ld_sample <= (state_next == S_LOAD);
      dp_start  <= (state_next == S_FIRE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rom_addr       <= ADDR_FIRST;
            idx            <= '0;
            err            <= '0;
            epoch_cnt      <= '0;
            last_epoch_err <= '0;
            done           <= 1'b0;
            converged      <= 1'b0;
            busy           <= 1'b1;
          end
        end
        S_WAIT: begin
          if (dp_done) begin
            if (dp_err && (err != '1)) err <= err + 8'd1;
            if (idx != IDX_LAST) begin
              idx      <= idx + IDX_W'(1);
              rom_addr <= rom_addr + ADDR_W'(1);
            end
          end
        end
        S_EPOCH_END: begin
          epoch_cnt      <= epoch_cnt + EPOCH_W'(1);
          last_epoch_err <= err;
          if (epoch_stop) begin
            converged <= (err == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            err      <= '0;
            idx      <= '0;
            rom_addr <= ADDR_FIRST;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
